// File: rtl/latency_block_mem_pkg.sv
// Shared definitions for the block-latency backing memory: block size, FSM encoding and the
// block word-packing macro (word i of a block sits at [i*W +: W]; the cache packs the same way).
package latency_block_mem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } mem_state_t;

   function automatic int block_size(input int offset_width);
      return 1 << offset_width;
   endfunction

endpackage

`ifndef LBM_BLK_WORD
`define LBM_BLK_WORD(blk, i, w) blk[(i)*(w) +: (w)]
`endif

// File: rtl/latency_block_mem_counter.sv
// Transfer latency timer: loaded with LATENCY-2 on acceptance, counts down while busy.
module mem_latency_counter #(
   parameter  int LATENCY   = 8,
   localparam int CNT_WIDTH = $clog2(LATENCY)
) (
   input  logic clk,
   input  logic rstn,
   input  logic load,
   input  logic dec,
   output logic zero
);

   logic [CNT_WIDTH-1:0] count;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         count <= '0;
      end else if (load) begin
         count <= CNT_WIDTH'(LATENCY - 2);
      end else if (dec) begin
         count <= count - CNT_WIDTH'(1);
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/latency_block_mem.sv
// Word-addressed backing memory serving whole-block refills/write-backs after a fixed latency.
// Optional MEM_STATS_EN adds saturating rd_count/wr_count commit counters.
//
// state   | meaning
// IDLE    | waiting for req; accepting latches block base, we and block_din
// BUSY    | counting down; commits at terminal count, aborts whenever req drops
// DONE    | block_valid high for this single cycle, req ignored
module latency_block_mem
   import latency_block_mem_pkg::*;
#(
   parameter  int DATA_WIDTH         = 32,
   parameter  int ADDR_WIDTH         = 10,
   parameter  int BLOCK_OFFSET_WIDTH = 3,
   parameter  int LATENCY            = 8,
   parameter      INIT_FILE          = "",
   localparam int BLOCK_SIZE         = block_size(BLOCK_OFFSET_WIDTH),
   localparam int BLOCK_WIDTH        = DATA_WIDTH * BLOCK_SIZE,
   localparam int DEPTH              = 1 << ADDR_WIDTH
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   req,
   input  logic                   we,
   input  logic [ADDR_WIDTH-1:0]  addr,
   input  logic [BLOCK_WIDTH-1:0] block_din,
   output logic                   block_valid,
   output logic [BLOCK_WIDTH-1:0] block_dout,
   output logic [DATA_WIDTH-1:0]  dout,
   input  logic [ADDR_WIDTH-1:0]  debug_addr,
   output logic [DATA_WIDTH-1:0]  debug_dout
`ifdef MEM_STATS_EN
   ,
   output logic [31:0]            rd_count,
   output logic [31:0]            wr_count
`endif
);

   logic [DATA_WIDTH-1:0]  mem [DEPTH];
   mem_state_t             state;
   logic [ADDR_WIDTH-1:0]  base;
   logic                   we_lat;
   logic [BLOCK_WIDTH-1:0] din_lat;
   logic                   cnt_load;
   logic                   cnt_dec;
   logic                   cnt_zero;
   logic                   commit;

   // Power-up image only; rstn never touches the array.
   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
   end

   assign cnt_load = (state == ST_IDLE) && req;
   assign cnt_dec  = (state == ST_BUSY) && req && !cnt_zero;
   assign commit   = (state == ST_BUSY) && req && cnt_zero;

   mem_latency_counter #(
      .LATENCY (LATENCY)
   ) u_counter (
      .clk  (clk),
      .rstn (rstn),
      .load (cnt_load),
      .dec  (cnt_dec),
      .zero (cnt_zero)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state       <= ST_IDLE;
         block_valid <= 1'b0;
         block_dout  <= '0;
         base        <= '0;
         we_lat      <= 1'b0;
         din_lat     <= '0;
      end else begin
         block_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (req) begin
                  base    <= {addr[ADDR_WIDTH-1:BLOCK_OFFSET_WIDTH], {BLOCK_OFFSET_WIDTH{1'b0}}};
                  we_lat  <= we;
                  din_lat <= block_din;
                  state   <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (!req) begin
                  state <= ST_IDLE;
               end else if (cnt_zero) begin
                  if (!we_lat) begin
                     for (int i = 0; i < BLOCK_SIZE; i++)
                        `LBM_BLK_WORD(block_dout, i, DATA_WIDTH) <= mem[base + ADDR_WIDTH'(i)];
                  end
                  block_valid <= 1'b1;
                  state       <= ST_DONE;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (commit && we_lat) begin
         for (int i = 0; i < BLOCK_SIZE; i++)
            mem[base + ADDR_WIDTH'(i)] <= `LBM_BLK_WORD(din_lat, i, DATA_WIDTH);
      end
   end

   assign dout       = mem[addr];
   assign debug_dout = mem[debug_addr];

`ifdef MEM_STATS_EN
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rd_count <= '0;
         wr_count <= '0;
      end else begin
         if (commit && !we_lat && rd_count != '1) rd_count <= rd_count + 32'd1;
         if (commit && we_lat && wr_count != '1)  wr_count <= wr_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_latency_block_mem.sv
// Self-checking bench for latency_block_mem: vector table, hand-written corner sequences and
// randomized transfers against an array/queue-level reference model (MEM_STATS_EN aware).
module tb_latency_block_mem;

   localparam int DW  = 32;
   localparam int AW  = 10;
   localparam int BOW = 3;
   localparam int BS  = 1 << BOW;
   localparam int LAT = 8;
   localparam int BW  = DW * BS;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          req = 1'b0;
   logic          we = 1'b0;
   logic [AW-1:0] addr = '0;
   logic [AW-1:0] debug_addr = '0;
   logic [BW-1:0] block_din = '0;
   logic          block_valid;
   logic [BW-1:0] block_dout;
   logic [DW-1:0] dout;
   logic [DW-1:0] debug_dout;
`ifdef MEM_STATS_EN
   logic [31:0]   rd_count;
   logic [31:0]   wr_count;
`endif

   always #5 clk = ~clk;

   latency_block_mem #(
      .DATA_WIDTH         (DW),
      .ADDR_WIDTH         (AW),
      .BLOCK_OFFSET_WIDTH (BOW),
      .LATENCY            (LAT),
      .INIT_FILE          ("")
   ) dut (
      .clk         (clk),
      .rstn        (rstn),
      .req         (req),
      .we          (we),
      .addr        (addr),
      .block_din   (block_din),
      .block_valid (block_valid),
      .block_dout  (block_dout),
      .dout        (dout),
      .debug_addr  (debug_addr),
      .debug_dout  (debug_dout)
`ifdef MEM_STATS_EN
      ,
      .rd_count    (rd_count),
      .wr_count    (wr_count)
`endif
   );

   logic [DW-1:0] model [1 << AW];
   logic [BW-1:0] last_rd;
   int            exp_rd;
   int            exp_wr;
   int            errors;
   int            checks;

   typedef struct {
      bit            w;
      logic [AW-1:0] a;
      logic [DW-1:0] seed;
      logic [AW-1:0] probe;
      logic [DW-1:0] exp_probe;
   } vec_t;

   vec_t tbl [8];

   task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_i(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [BW-1:0] pattern(input logic [DW-1:0] seed);
      logic [BW-1:0] r;
      for (int i = 0; i < BS; i++) r[i*DW +: DW] = seed + DW'(i);
      return r;
   endfunction

   function automatic int block_base(input logic [AW-1:0] a);
      return (int'(a) / BS) * BS;
   endfunction

   function automatic logic [BW-1:0] model_block(input logic [AW-1:0] a);
      logic [BW-1:0] r;
      int b;
      b = block_base(a);
      for (int i = 0; i < BS; i++) r[i*DW +: DW] = model[b + i];
      return r;
   endfunction

   task automatic model_commit(input bit w, input logic [AW-1:0] a, input logic [BW-1:0] d);
      int b;
      b = block_base(a);
      if (w) begin
         for (int i = 0; i < BS; i++) model[b + i] = d[i*DW +: DW];
         exp_wr++;
      end else begin
         last_rd = model_block(a);
         exp_rd++;
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic start(input bit w, input logic [AW-1:0] a, input logic [BW-1:0] d);
      we = w;
      addr = a;
      block_din = d;
      req = 1'b1;
   endtask

   // Cycle index (relative to the request cycle) of the next block_valid, -1 on timeout.
   task automatic wait_valid(output int k);
      bit found;
      found = 1'b0;
      k = -1;
      for (int c = 1; c <= 40; c++) begin
         if (!found) begin
            tick();
            if (block_valid === 1'b1) begin
               found = 1'b1;
               k = c;
            end
         end
      end
   endtask

   task automatic count_pulses(input int n, output int p);
      p = 0;
      for (int c = 0; c < n; c++) begin
         tick();
         if (block_valid === 1'b1) p++;
      end
   endtask

   task automatic check_block_mem(input string name, input logic [AW-1:0] a);
      int b;
      b = block_base(a);
      for (int i = 0; i < BS; i++) begin
         debug_addr = AW'(b + i);
         #1;
         chk(name, BW'(debug_dout), BW'(model[b + i]));
      end
   endtask

   // Full transfer, req dropped in the DONE cycle; dout/debug_dout probed in DONE.
   task automatic transfer(input bit w, input logic [AW-1:0] a, input logic [BW-1:0] d,
                           input logic [AW-1:0] probe, input string name);
      int k;
      int p;
      start(w, a, d);
      wait_valid(k);
      req = 1'b0;
      chk_i({name, " latency"}, k, LAT);
      model_commit(w, a, d);
      chk({name, " block_dout"}, block_dout, last_rd);
      addr = probe;
      debug_addr = probe;
      #1;
      chk({name, " dout"}, BW'(dout), BW'(model[probe]));
      chk({name, " debug_dout"}, BW'(debug_dout), BW'(model[probe]));
      count_pulses(2, p);
      chk_i({name, " single pulse"}, p, 0);
   endtask

   task automatic aborted(input bit w, input logic [AW-1:0] a, input logic [BW-1:0] d,
                          input int drop_cycle, input string name);
      int p;
      int q;
      start(w, a, d);
      count_pulses(drop_cycle, p);
      req = 1'b0;
      count_pulses(LAT + 3, q);
      chk_i({name, " no pulse"}, p + q, 0);
      chk({name, " block_dout kept"}, block_dout, last_rd);
      check_block_mem({name, " mem kept"}, a);
   endtask

   task automatic do_reset;
      rstn = 1'b0;
      req = 1'b0;
      #1;
      last_rd = '0;
      exp_rd = 0;
      exp_wr = 0;
      tick();
      rstn = 1'b1;
      tick();
   endtask

   initial begin
      int k;
      int p;
      int pulses [2];
      int np;
      logic [BW-1:0] d;
      logic [AW-1:0] a;
      logic [AW-1:0] pr;
      bit w;

      errors = 0;
      checks = 0;
      exp_rd = 0;
      exp_wr = 0;
      last_rd = '0;
      for (int i = 0; i < (1 << AW); i++) model[i] = '0;

      tbl[0] = '{1'b1, 10'h020, 32'hA0,       10'h025, 32'hA5};
      tbl[1] = '{1'b0, 10'h027, 32'hA0,       10'h020, 32'hA0};
      tbl[2] = '{1'b1, 10'h013, 32'h10,       10'h017, 32'h17};
      tbl[3] = '{1'b0, 10'h013, 32'h10,       10'h013, 32'h13};
      tbl[4] = '{1'b1, 10'h3FF, 32'h1000,     10'h3FF, 32'h1007};
      tbl[5] = '{1'b0, 10'h3F8, 32'h1000,     10'h3F8, 32'h1000};
      tbl[6] = '{1'b1, 10'h000, 32'hFFFFFFF8, 10'h007, 32'hFFFFFFFF};
      tbl[7] = '{1'b0, 10'h002, 32'hFFFFFFF8, 10'h008, 32'h0};

      #2;
      chk("reset block_valid", BW'(block_valid), '0);
      chk("reset block_dout", block_dout, '0);
      tick();
      rstn = 1'b1;
      tick();
      chk("idle block_valid", BW'(block_valid), '0);
      chk("zero mem dout", BW'(dout), '0);

      // Vector table: writes then reads of the same blocks, including the top block.
      for (int t = 0; t < 8; t++) begin
         transfer(tbl[t].w, tbl[t].a, pattern(tbl[t].seed), tbl[t].probe, $sformatf("vec%0d", t));
         chk($sformatf("vec%0d probe const", t), BW'(dout), BW'(tbl[t].exp_probe));
         if (!tbl[t].w)
            chk($sformatf("vec%0d block const", t), block_dout, pattern(tbl[t].seed));
      end

      // Write-back then refill with req held high: pulses at 8 and 17.
      np = 0;
      pulses[0] = -1;
      pulses[1] = -1;
      d = pattern(32'h400);
      start(1'b1, 10'h040, d);
      for (int c = 1; c <= 30; c++) begin
         tick();
         if (block_valid === 1'b1) begin
            if (np < 2) pulses[np] = c;
            np++;
            if (np == 1) begin
               model_commit(1'b1, 10'h040, d);
               we = 1'b0;
               addr = 10'h080;
            end else if (np == 2) begin
               model_commit(1'b0, 10'h080, '0);
               chk("b2b refill data", block_dout, last_rd);
               req = 1'b0;
            end
         end
      end
      req = 1'b0;
      chk_i("b2b pulse count", np, 2);
      chk_i("b2b first pulse", pulses[0], LAT);
      chk_i("b2b second pulse", pulses[1], 2 * LAT + 1);
      check_block_mem("b2b writeback mem", 10'h040);

      // Spurious re-request for one cycle after a refill has no side effect.
      start(1'b0, 10'h020, '0);
      wait_valid(k);
      chk_i("spurious first latency", k, LAT);
      model_commit(1'b0, 10'h020, '0);
      tick();
      req = 1'b0;
      count_pulses(LAT + 4, p);
      chk_i("spurious no pulse", p, 0);
      chk("spurious block_dout", block_dout, last_rd);

      // Aborts: drop at cycle 4, and at both ends of the BUSY window.
      aborted(1'b1, 10'h020, pattern(32'hBAD0), 4, "abort wr c4");
      aborted(1'b1, 10'h0C0, pattern(32'hBAD8), 1, "abort wr c1");
      aborted(1'b0, 10'h3F8, '0, LAT - 1, "abort rd last");

      // Reset in cycle 5 of a write: nothing committed, next request completes normally.
      start(1'b1, 10'h100, pattern(32'h5000));
      count_pulses(5, p);
      rstn = 1'b0;
      #1;
      chk_i("rst mid no pulse", p, 0);
      chk("rst mid block_valid", BW'(block_valid), '0);
      chk("rst mid block_dout", block_dout, '0);
      last_rd = '0;
      exp_rd = 0;
      exp_wr = 0;
      tick();
      rstn = 1'b1;
      req = 1'b0;
      tick();
      check_block_mem("rst mid mem kept", 10'h100);
      transfer(1'b0, 10'h100, '0, 10'h104, "rst after read");

      // Reset in DONE of a write: the commit already happened and stays.
      d = pattern(32'h7700);
      start(1'b1, 10'h108, d);
      wait_valid(k);
      chk_i("rst done latency", k, LAT);
      model_commit(1'b1, 10'h108, d);
      do_reset();
      check_block_mem("rst done mem kept", 10'h108);

      // Randomized transfers and aborts against the model.
      for (int n = 0; n < 40; n++) begin
         w = 1'($urandom_range(0, 1));
         a = AW'($urandom_range(0, (1 << AW) - 1));
         pr = AW'($urandom_range(0, (1 << AW) - 1));
         for (int i = 0; i < BS; i++) d[i*DW +: DW] = $urandom;
         if ($urandom_range(0, 4) == 0)
            aborted(w, a, d, int'($urandom_range(1, LAT - 1)), $sformatf("rnd%0d abort", n));
         else
            transfer(w, a, d, pr, $sformatf("rnd%0d", n));
      end

`ifdef MEM_STATS_EN
      chk_i("rnd rd_count", int'(rd_count), exp_rd);
      chk_i("rnd wr_count", int'(wr_count), exp_wr);
`endif

      // Stats mix: 3 reads, 2 writes, 1 aborted read.
      do_reset();
      transfer(1'b0, 10'h020, '0, 10'h020, "mix rd0");
      transfer(1'b1, 10'h200, pattern(32'hC0), 10'h203, "mix wr0");
      transfer(1'b0, 10'h200, '0, 10'h207, "mix rd1");
      aborted(1'b0, 10'h040, '0, 3, "mix abort rd");
      transfer(1'b1, 10'h208, pattern(32'hD0), 10'h20F, "mix wr1");
      transfer(1'b0, 10'h208, '0, 10'h208, "mix rd2");
      chk("mix final read", block_dout, pattern(32'hD0));
      chk_i("mix model rd", exp_rd, 3);
      chk_i("mix model wr", exp_wr, 2);
`ifdef MEM_STATS_EN
      chk_i("mix rd_count", int'(rd_count), 3);
      chk_i("mix wr_count", int'(wr_count), 2);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
